// File: rtl/gpio_bank_m.sv
// gpio_bank_m: parametrised GPIO port with per-bit direction, atomic set/clear,
// synchronised and glitch-filtered inputs, and masked sticky edge interrupts.
module gpio_bank_m #(
    parameter int GPIO_SZ       = 7,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0
) (
    input  logic               cpu_ck_phi1,
    input  logic               reset,
    input  logic               sel,
    input  logic               rnw,
    input  logic [2:0]         addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    input  logic [GPIO_SZ-1:0] gpio_in,
    output logic [GPIO_SZ-1:0] gpio_out,
    output logic [GPIO_SZ-1:0] gpio_oe,
    output logic               irq
);
    localparam logic [2:0] ADDR_DIR     = 3'd0;
    localparam logic [2:0] ADDR_DATA    = 3'd1;
    localparam logic [2:0] ADDR_SET     = 3'd2;
    localparam logic [2:0] ADDR_CLR     = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN = 3'd5;
    localparam logic [2:0] ADDR_MASK    = 3'd6;
    localparam logic [2:0] ADDR_STATUS  = 3'd7;

    logic [GPIO_SZ-1:0] dir_q, lat_q, rise_en_q, fall_en_q, mask_q, status_q, prev_q;
    logic [GPIO_SZ-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_SZ-1:0] sync, filt, rise, fall, evt, wd, st_clr, rd_val;
    logic               wr;
    logic               unused_wdata;

    assign wr           = sel & ~rnw;
    assign wd           = wdata[GPIO_SZ-1:0];
    assign unused_wdata = ^wdata;

    always_ff @(posedge cpu_ck_phi1) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end
    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_nofilt
            assign filt = sync;
        end else begin : g_filt
            localparam int CW = $clog2(FILTER_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
            logic [CW-1:0]      cnt_q [GPIO_SZ];
            logic [GPIO_SZ-1:0] filt_q;

            // accept on the edge where the count of differing cycles would reach FILTER_CYCLES
            always_ff @(posedge cpu_ck_phi1) begin
                for (int i = 0; i < GPIO_SZ; i++) begin
                    if (reset) begin
                        cnt_q[i]  <= '0;
                        filt_q[i] <= 1'b0;
                    end else if (sync[i] == filt_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        cnt_q[i]  <= '0;
                        filt_q[i] <= sync[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end
            end
            assign filt = filt_q;
        end
    endgenerate

    assign rise   = filt & ~prev_q;
    assign fall   = ~filt & prev_q;
    assign evt    = dir_q & ((rise & rise_en_q) | (fall & fall_en_q));
    assign st_clr = (wr && addr == ADDR_STATUS) ? wd : '0;

    // events use the pre-write DIR/enables; a new event wins over a same-edge W1C
    always_ff @(posedge cpu_ck_phi1) begin
        if (reset) begin
            dir_q     <= '1;
            lat_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            mask_q    <= '0;
            status_q  <= '0;
            prev_q    <= '0;
        end else begin
            prev_q   <= filt;
            status_q <= (status_q & ~st_clr) | evt;
            if (wr) begin
                case (addr)
                    ADDR_DIR:     dir_q     <= wd;
                    ADDR_DATA:    lat_q     <= wd;
                    ADDR_SET:     lat_q     <= lat_q | wd;
                    ADDR_CLR:     lat_q     <= lat_q & ~wd;
                    ADDR_RISE_EN: rise_en_q <= wd;
                    ADDR_FALL_EN: fall_en_q <= wd;
                    ADDR_MASK:    mask_q    <= wd;
                    default:      ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_DIR:     rd_val = dir_q;
            ADDR_DATA:    rd_val = (dir_q & filt) | (~dir_q & lat_q);
            ADDR_RISE_EN: rd_val = rise_en_q;
            ADDR_FALL_EN: rd_val = fall_en_q;
            ADDR_MASK:    rd_val = mask_q;
            ADDR_STATUS:  rd_val = status_q;
            default:      rd_val = '0;
        endcase
        rdata = '0;
        if (sel && rnw) rdata[GPIO_SZ-1:0] = rd_val;
    end

    assign gpio_out = lat_q;
    assign gpio_oe  = ~dir_q;
    assign irq      = |(status_q & mask_q);
endmodule
